rd_latency_n_to_0: RTL and testbench

Parametrised read-latency adapter. It turns a fixed-latency read source (data returns exactly LATENCY cycles after `in_rd_en`) into a zero-latency, show-ahead read port. It prefetches into a DEPTH-entry FIFO, using credits so that stored words plus in-flight reads never exceed DEPTH. It adds flush, occupancy reporting and return-timing checking, and sits between each channel's storage read port and the multichannel output arbiter.

---
 rtl/rd_latency_n_to_0_if.sv | 30 +++
 rtl/rd_latency_n_to_0.sv | 99 +++++++++
 tb/tb_rd_latency_n_to_0.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/rd_latency_n_to_0_if.sv
// Read-side bus of the latency adapter: the fixed-latency source port and the
// show-ahead consumer port. The adapter takes the slave view.
interface rd_latency_n_to_0_if #(
    parameter int WIDTH = 32
);
    logic             in_rd_en;
    logic             in_rd_valid;
    logic [WIDTH-1:0] in_rd_data;
    logic             out_rd_en;
    logic             out_rd_valid;
    logic [WIDTH-1:0] out_rd_data;

    modport slave (
        output in_rd_en,
        input  in_rd_valid,
        input  in_rd_data,
        input  out_rd_en,
        output out_rd_valid,
        output out_rd_data
    );

    modport master (
        input  in_rd_en,
        output in_rd_valid,
        output in_rd_data,
        output out_rd_en,
        input  out_rd_valid,
        input  out_rd_data
    );
endinterface

// File: rtl/rd_latency_n_to_0.sv
// Turns a fixed-latency read source into a zero-latency show-ahead port by
// credit-limited prefetch into a DEPTH-entry FIFO, with flush and return-timing checks.
module rd_latency_n_to_0 #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    parameter int DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_enable,
    input  logic                       i_flush,
    rd_latency_n_to_0_if.slave         bus,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_err_protocol
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   LIM_CREDIT = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIM_COUNT  = CW'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PW-1:0]      r_wr_ptr;
    logic [PW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [CW-1:0]      r_inflight;
    logic [LATENCY-1:0] r_tok_v;
    logic [LATENCY-1:0] r_tok_d;
    logic               r_err;

    logic [CW:0] w_credits;
    logic        w_issue;
    logic        w_expected;
    logic        w_discard;
    logic        w_accept;
    logic        w_full;
    logic        w_capture;
    logic        w_overflow;
    logic        w_pop;
    logic        w_err_evt;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credits count both stored words and reads still in the source pipeline.
    // rst_n gates the request so it is low for the whole reset, not just after it.
    assign w_credits  = {1'b0, r_inflight} + {1'b0, r_count};
    assign w_issue    = rst_n & i_enable & ~i_flush & (w_credits < LIM_CREDIT);

    assign w_expected = r_tok_v[LATENCY-1];
    assign w_discard  = r_tok_d[LATENCY-1];
    assign w_accept   = bus.in_rd_valid & w_expected & ~w_discard & ~i_flush;
    assign w_full     = (r_count == LIM_COUNT);
    assign w_capture  = w_accept & ~w_full;
    assign w_overflow = w_accept & w_full;
    assign w_pop      = bus.out_rd_en & (r_count != '0) & ~i_flush;

    assign w_err_evt  = (bus.in_rd_valid & ~w_expected & ~i_flush)
                      | (w_expected & ~bus.in_rd_valid)
                      | w_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_tok_v    <= '0;
            r_tok_d    <= '0;
            r_err      <= 1'b0;
        end else begin
            // Flush marks every live token as discard; its credit is released
            // only when it retires, so in-flight returns cannot oversubscribe.
            r_tok_v    <= (r_tok_v << 1) | LATENCY'(w_issue);
            r_tok_d    <= (i_flush ? (r_tok_d | r_tok_v) : r_tok_d) << 1;
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_expected);
            r_err      <= r_err | w_err_evt;
            if (i_flush) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_capture) r_wr_ptr <= f_next(r_wr_ptr);
                if (w_pop)     r_rd_ptr <= f_next(r_rd_ptr);
                r_count <= r_count + CW'(w_capture) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) r_mem[r_wr_ptr] <= bus.in_rd_data;
    end

    assign bus.in_rd_en     = w_issue;
    assign bus.out_rd_valid = (r_count != '0);
    assign bus.out_rd_data  = r_mem[r_rd_ptr];
    assign o_level          = r_count;
    assign o_err_protocol   = r_err;
endmodule

// File: tb/tb_rd_latency_n_to_0.sv
// Directed bench: instance A (LATENCY=1, DEPTH=3) streams; instance B
// (LATENCY=3, DEPTH=4) covers credits, flush, timing error, wrap-around and reset.
module tb_rd_latency_n_to_0;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       a_en = 1'b0, a_fl = 1'b0, b_en = 1'b0, b_fl = 1'b0;
    logic [1:0] a_level;
    logic [2:0] b_level;
    logic       a_err, b_err;

    rd_latency_n_to_0_if #(.WIDTH(32)) a_if ();
    rd_latency_n_to_0_if #(.WIDTH(32)) b_if ();

    rd_latency_n_to_0 #(.WIDTH(32), .LATENCY(1), .DEPTH(3)) u_a (
        .clk(clk), .rst_n(rst_n), .i_enable(a_en), .i_flush(a_fl),
        .bus(a_if.slave), .o_level(a_level), .o_err_protocol(a_err)
    );
    rd_latency_n_to_0 #(.WIDTH(32), .LATENCY(3), .DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .i_enable(b_en), .i_flush(b_fl),
        .bus(b_if.slave), .o_level(b_level), .o_err_protocol(b_err)
    );

    // Source models: return an incrementing value b_dly cycles after each request.
    logic [9:0]  a_sv = '0, b_sv = '0;
    logic [31:0] a_sd [10];
    logic [31:0] b_sd [10];
    logic [31:0] a_next = '0, b_next = '0;
    logic [3:0]  b_dly = 4'd3;

    always @(posedge clk) begin
        a_sv    <= {a_sv[8:0], a_if.in_rd_en};
        b_sv    <= {b_sv[8:0], b_if.in_rd_en};
        a_sd[0] <= a_next;
        b_sd[0] <= b_next;
        for (int k = 1; k < 10; k++) begin
            a_sd[k] <= a_sd[k-1];
            b_sd[k] <= b_sd[k-1];
        end
        if (a_if.in_rd_en) a_next <= a_next + 1;
        if (b_if.in_rd_en) b_next <= b_next + 1;
    end

    assign a_if.in_rd_valid = a_sv[0];
    assign a_if.in_rd_data  = a_sd[0];
    assign b_if.in_rd_valid = b_sv[b_dly-4'd1];
    assign b_if.in_rd_data  = b_sd[b_dly-4'd1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] pat = 16'b1011_0010_1110_0101;
    logic [31:0] exp_w;
    int          got;

    initial begin
        a_if.out_rd_en = 1'b0;
        b_if.out_rd_en = 1'b0;
        b_en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_rd_en", b_if.in_rd_en, 1'b0);
        chk("rst_valid", b_if.out_rd_valid, 1'b0);
        chk("rst_level", b_level, 3'd0);
        chk("rst_err", b_err, 1'b0);
        b_en = 1'b0;
        #10 rst_n = 1'b1;

        // A: continuous streaming, first word at LATENCY+1, then one per cycle.
        step(); a_en = 1'b1; a_if.out_rd_en = 1'b1; #1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) begin step(); #1; end
            chk("a_issue", a_if.in_rd_en, 1'b1);
            chk("a_valid", a_if.out_rd_valid, i >= 2);
            if (i >= 2) chk("a_data", a_if.out_rd_data, 32'(i - 2));
        end
        chk("a_err", a_err, 1'b0);
        step(); a_en = 1'b0; #1;

        // B: fill with no pop; exactly four reads issue.
        for (int c = 0; c < 8; c++) begin
            step();
            if (c == 0) b_en = 1'b1;
            #1;
            chk("b_fill_issue", b_if.in_rd_en, c <= 3);
        end
        chk("b_full_level", b_level, 3'd4);
        chk("b_full_valid", b_if.out_rd_valid, 1'b1);
        chk("b_full_data", b_if.out_rd_data, 32'd0);
        step(); b_if.out_rd_en = 1'b1; #1;
        chk("b_no_comb_path", b_if.in_rd_en, 1'b0);
        step(); b_if.out_rd_en = 1'b0; #1;
        chk("b_pop_level", b_level, 3'd3);
        chk("b_pop_reissue", b_if.in_rd_en, 1'b1);
        chk("b_pop_data", b_if.out_rd_data, 32'd1);
        step(); #1;
        chk("b_reblock", b_if.in_rd_en, 1'b0);
        step(); #1;
        step(); #1;
        chk("b_land_pre", b_level, 3'd3);
        step(); b_en = 1'b0; b_if.out_rd_en = 1'b1; #1;
        chk("b_land_post", b_level, 3'd4);
        chk("b_drain_data", b_if.out_rd_data, 32'd1);
        for (int k = 2; k <= 4; k++) begin
            step(); #1;
            chk("b_drain_data", b_if.out_rd_data, 32'(k));
            chk("b_drain_level", b_level, 3'(5 - k));
        end
        step(); b_if.out_rd_en = 1'b0; #1;
        chk("b_drained", b_if.out_rd_valid, 1'b0);

        // Flush with two words stored and two in flight (data 5..8 issued).
        step(); b_en = 1'b1; #1;
        for (int c = 1; c <= 5; c++) begin
            step();
            if (c == 5) b_fl = 1'b1;
            #1;
        end
        chk("fl_pre_level", b_level, 3'd2);
        chk("fl_no_issue", b_if.in_rd_en, 1'b0);
        step(); b_fl = 1'b0; #1;
        chk("fl_level", b_level, 3'd0);
        chk("fl_valid", b_if.out_rd_valid, 1'b0);
        chk("fl_reissue", b_if.in_rd_en, 1'b1);
        step(); b_en = 1'b0; #1;
        for (int c = 7; c <= 9; c++) begin
            if (c > 7) begin step(); #1; end
            chk("fl_dropped", b_if.out_rd_valid, 1'b0);
        end
        step(); b_if.out_rd_en = 1'b1; #1;
        chk("fl_first_data", b_if.out_rd_data, 32'd9);
        chk("fl_level_one", b_level, 3'd1);
        chk("fl_err", b_err, 1'b0);
        step(); b_if.out_rd_en = 1'b0; b_dly = 4'd4; #1;
        chk("fl_empty", b_level, 3'd0);

        // Source one cycle late: error visible the cycle after the expected slot.
        step(); b_en = 1'b1; #1;
        chk("late_issue", b_if.in_rd_en, 1'b1);
        step(); b_en = 1'b0; #1;
        step(); #1;
        step(); #1;
        chk("late_err_pre", b_err, 1'b0);
        step(); #1;
        chk("late_err", b_err, 1'b1);
        chk("late_level", b_level, 3'd0);
        for (int c = 0; c < 4; c++) step();
        #1;
        chk("late_sticky", b_err, 1'b1);
        b_dly = 4'd3;

        // Wrap-around: fixed gap pattern on pop, order and level bound checked.
        exp_w = b_next;
        got   = 0;
        step(); b_en = 1'b1; #1;
        for (int i = 0; i < 80 && got < 10; i++) begin
            step();
            b_if.out_rd_en = pat[i[3:0]];
            #1;
            chk("wrap_level_max", b_level <= 3'd4, 1'b1);
            if (b_if.out_rd_en && b_if.out_rd_valid) begin
                chk("wrap_order", b_if.out_rd_data, exp_w);
                exp_w = exp_w + 1;
                got++;
            end
        end
        chk("wrap_count", got, 10);
        step(); b_en = 1'b0; b_if.out_rd_en = 1'b0; b_fl = 1'b1; #1;
        step(); b_fl = 1'b0; #1;
        for (int c = 0; c < 5; c++) step();
        #1;
        chk("wrap_flushed", b_level, 3'd0);

        // Mid-stream asynchronous reset with the source left running.
        step(); b_en = 1'b1; b_if.out_rd_en = 1'b1; #1;
        for (int c = 0; c < 6; c++) step();
        #1;
        chk("mid_streaming", b_if.out_rd_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("ares_in_rd_en", b_if.in_rd_en, 1'b0);
        chk("ares_valid", b_if.out_rd_valid, 1'b0);
        chk("ares_level", b_level, 3'd0);
        chk("ares_err", b_err, 1'b0);
        b_en = 1'b0;
        #1 rst_n = 1'b1;
        step(); #1;
        step(); #1;
        step(); #1;
        chk("stale_err", b_err, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
